prefetch_rd_slice: RTL and testbench



---
 rtl/prefetch_rd_slice.sv | 170 +++++++++++++++++
 tb/tb_prefetch_rd_slice.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_rd_slice.sv
// Registered AXI read-path slice: two-entry skid buffers on AR and R, with a
// programmable cap on read bursts in flight at DDR and a sticky underflow flag.

// Handshake rule for every channel here: a transfer happens on a rising clk
// edge where valid && ready; valid never waits on ready, and once valid is
// high the payload holds stable until that transfer.
module prefetch_rd_slice_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid, main_valid_nxt;
    logic [W-1:0] main_data, main_data_nxt;
    logic         skid_valid, skid_valid_nxt;
    logic [W-1:0] skid_data, skid_data_nxt;
    logic         drain, accept;

    assign drain     = main_valid && out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // in_ready is low whenever skid is full, so drain-from-skid never
    // coincides with an accept.
    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (drain) begin
            if (skid_valid) begin
                main_data_nxt  = skid_data;
                skid_valid_nxt = 1'b0;
            end else if (accept) begin
                main_data_nxt = in_data;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = in_data;
            end else begin
                skid_valid_nxt = 1'b1;
                skid_data_nxt  = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            main_valid <= main_valid_nxt;
            main_data  <= main_data_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            in_ready   <= !skid_valid_nxt;
        end
    end

endmodule

module prefetch_rd_slice #(
    parameter int ADDR_BITS            = 16,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int OUTST_WIDTH          = 3
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              s_ar_valid,
    output logic                              s_ar_ready,
    input  logic [ADDR_BITS-1:0]              s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0]        s_ar_len,
    input  logic [TID_WIDTH-1:0]              s_ar_id,
    output logic                              m_ar_valid,
    input  logic                              m_ar_ready,
    output logic [ADDR_BITS-1:0]              m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]        m_ar_len,
    output logic [TID_WIDTH-1:0]              m_ar_id,
    input  logic                              m_r_valid,
    output logic                              m_r_ready,
    input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] m_r_data,
    input  logic [TID_WIDTH-1:0]              m_r_id,
    input  logic                              m_r_last,
    output logic                              s_r_valid,
    input  logic                              s_r_ready,
    output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] s_r_data,
    output logic [TID_WIDTH-1:0]              s_r_id,
    output logic                              s_r_last,
    input  logic [OUTST_WIDTH:0]              crs_outstLimit,
    output logic [OUTST_WIDTH:0]              outstCnt,
    output logic                              err_underflow
);

    localparam int DATA_W = 8 << LOG_BLOCK_DATA_BYTES;
    localparam int AR_W   = ADDR_BITS + BURST_LEN_WIDTH + TID_WIDTH;
    localparam int R_W    = DATA_W + TID_WIDTH + 1;

    logic            ar_main_valid;
    logic            ar_gate;
    logic            ar_fire;
    logic            r_last_fire;
    logic [AR_W-1:0] ar_out;
    logic [R_W-1:0]  r_out;

    // AR main entry holds its payload while the in-flight cap is reached.
    assign ar_gate    = (outstCnt < crs_outstLimit);
    assign m_ar_valid = ar_main_valid && ar_gate;

    prefetch_rd_slice_skid #(.W(AR_W)) u_ar_skid (
        .clk       (clk),
        .resetN    (resetN),
        .in_valid  (s_ar_valid),
        .in_ready  (s_ar_ready),
        .in_data   ({s_ar_id, s_ar_len, s_ar_addr}),
        .out_valid (ar_main_valid),
        .out_ready (m_ar_ready && ar_gate),
        .out_data  (ar_out)
    );

    assign {m_ar_id, m_ar_len, m_ar_addr} = ar_out;

    prefetch_rd_slice_skid #(.W(R_W)) u_r_skid (
        .clk       (clk),
        .resetN    (resetN),
        .in_valid  (m_r_valid),
        .in_ready  (m_r_ready),
        .in_data   ({m_r_last, m_r_id, m_r_data}),
        .out_valid (s_r_valid),
        .out_ready (s_r_ready),
        .out_data  (r_out)
    );

    assign {s_r_last, s_r_id, s_r_data} = r_out;

    assign ar_fire     = m_ar_valid && m_ar_ready;
    assign r_last_fire = m_r_valid && m_r_ready && m_r_last;

    // Increments only happen below the limit, so the counter cannot wrap.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outstCnt      <= '0;
            err_underflow <= 1'b0;
        end else if (ar_fire && !r_last_fire) begin
            outstCnt <= outstCnt + {{OUTST_WIDTH{1'b0}}, 1'b1};
        end else if (!ar_fire && r_last_fire) begin
            if (outstCnt == '0) begin
                err_underflow <= 1'b1;
            end else begin
                outstCnt <= outstCnt - {{OUTST_WIDTH{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_prefetch_rd_slice.sv
// Bench for prefetch_rd_slice: directed scenarios, then randomized traffic
// checked against a transaction-level model built from queues.
module tb_prefetch_rd_slice;

    logic        clk = 1'b0;
    logic        resetN;
    logic        s_ar_valid, s_ar_ready;
    logic [15:0] s_ar_addr;
    logic [7:0]  s_ar_len, s_ar_id;
    logic        m_ar_valid, m_ar_ready;
    logic [15:0] m_ar_addr;
    logic [7:0]  m_ar_len, m_ar_id;
    logic        m_r_valid, m_r_ready;
    logic [7:0]  m_r_data, m_r_id;
    logic        m_r_last;
    logic        s_r_valid, s_r_ready;
    logic [7:0]  s_r_data, s_r_id;
    logic        s_r_last;
    logic [3:0]  crs_outstLimit;
    logic [3:0]  outstCnt;
    logic        err_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: queues of payloads owned by each slice channel, bursts the
    // DDR still owes, and the expected counter/flag.
    logic [31:0] ar_exp_q[$];
    logic [31:0] r_exp_q[$];
    logic [15:0] ddr_q[$];
    int          beat_idx;
    int          cnt_m;
    logic        err_m;
    logic        ar_in_hs, ar_out_hs, r_in_hs, r_out_hs;
    logic        stop_stim;

    prefetch_rd_slice dut (
        .clk            (clk),
        .resetN         (resetN),
        .s_ar_valid     (s_ar_valid),
        .s_ar_ready     (s_ar_ready),
        .s_ar_addr      (s_ar_addr),
        .s_ar_len       (s_ar_len),
        .s_ar_id        (s_ar_id),
        .m_ar_valid     (m_ar_valid),
        .m_ar_ready     (m_ar_ready),
        .m_ar_addr      (m_ar_addr),
        .m_ar_len       (m_ar_len),
        .m_ar_id        (m_ar_id),
        .m_r_valid      (m_r_valid),
        .m_r_ready      (m_r_ready),
        .m_r_data       (m_r_data),
        .m_r_id         (m_r_id),
        .m_r_last       (m_r_last),
        .s_r_valid      (s_r_valid),
        .s_r_ready      (s_r_ready),
        .s_r_data       (s_r_data),
        .s_r_id         (s_r_id),
        .s_r_last       (s_r_last),
        .crs_outstLimit (crs_outstLimit),
        .outstCnt       (outstCnt),
        .err_underflow  (err_underflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_ar(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] id);
        s_ar_valid = 1'b1;
        s_ar_addr  = addr;
        s_ar_len   = len;
        s_ar_id    = id;
    endtask

    task automatic drive_r(input logic [7:0] data, input logic [7:0] id, input logic last);
        m_r_valid = 1'b1;
        m_r_data  = data;
        m_r_id    = id;
        m_r_last  = last;
    endtask

    task automatic last_beat_cycle();
        drive_r(8'h11, 8'h0, 1'b1);
        tick();
        m_r_valid = 1'b0;
    endtask

    // ---------------- scoreboard / model ----------------
    task automatic check_state();
        check_eq("rnd_s_ar_ready", {31'b0, s_ar_ready}, {31'b0, ar_exp_q.size() < 2});
        check_eq("rnd_m_ar_valid", {31'b0, m_ar_valid},
                 {31'b0, (ar_exp_q.size() > 0) && (cnt_m < int'(crs_outstLimit))});
        check_eq("rnd_m_r_ready", {31'b0, m_r_ready}, {31'b0, r_exp_q.size() < 2});
        check_eq("rnd_s_r_valid", {31'b0, s_r_valid}, {31'b0, r_exp_q.size() > 0});
        check_eq("rnd_outst_cnt", {28'b0, outstCnt}, cnt_m);
        check_eq("rnd_err", {31'b0, err_underflow}, {31'b0, err_m});
    endtask

    task automatic observe();
        ar_in_hs  = s_ar_valid && s_ar_ready;
        ar_out_hs = m_ar_valid && m_ar_ready;
        r_in_hs   = m_r_valid && m_r_ready;
        r_out_hs  = s_r_valid && s_r_ready;
        if (ar_out_hs && ar_exp_q.size() > 0) begin
            check_eq("rnd_ar_payload", {m_ar_id, m_ar_len, m_ar_addr}, ar_exp_q.pop_front());
            ddr_q.push_back({m_ar_id, m_ar_len});
        end
        if (ar_in_hs) ar_exp_q.push_back({s_ar_id, s_ar_len, s_ar_addr});
        if (r_out_hs && r_exp_q.size() > 0)
            check_eq("rnd_r_payload", {15'b0, s_r_last, s_r_id, s_r_data}, r_exp_q.pop_front());
        if (r_in_hs) begin
            r_exp_q.push_back({15'b0, m_r_last, m_r_id, m_r_data});
            if (m_r_last) begin
                if (ddr_q.size() > 0) void'(ddr_q.pop_front());
                beat_idx = 0;
            end else begin
                beat_idx++;
            end
        end
        // Bursts in flight: +1 per issued AR, -1 per last beat, sticky error on underflow.
        if (ar_out_hs && !(r_in_hs && m_r_last)) cnt_m++;
        else if (!ar_out_hs && r_in_hs && m_r_last) begin
            if (cnt_m == 0) err_m = 1'b1;
            else cnt_m--;
        end
    endtask

    task automatic drive_random();
        logic [15:0] burst;
        if (!s_ar_valid || ar_in_hs) begin
            s_ar_valid = !stop_stim && ($urandom_range(0, 9) < 6);
            s_ar_addr  = 16'($urandom);
            s_ar_len   = 8'($urandom_range(0, 3));
            s_ar_id    = 8'($urandom);
        end
        m_ar_ready = stop_stim || ($urandom_range(0, 9) < 7);
        s_r_ready  = stop_stim || ($urandom_range(0, 9) < 7);
        if (!m_r_valid || r_in_hs) begin
            if (ddr_q.size() > 0 && (stop_stim || $urandom_range(0, 9) < 7)) begin
                burst = ddr_q[0];
                drive_r(8'($urandom), burst[15:8], (beat_idx == int'(burst[7:0])));
            end else begin
                m_r_valid = 1'b0;
            end
        end
        if (stop_stim) crs_outstLimit = 4'd4;
        else if ($urandom_range(0, 39) == 0) crs_outstLimit = 4'($urandom_range(0, 4));
    endtask

    task automatic model_cycle();
        check_state();
        drive_random();
        #1;
        observe();
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   drain_cycles;
        logic busy;
        resetN = 1'b0;
        s_ar_valid = 1'b0; s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0;
        m_ar_ready = 1'b0;
        m_r_valid = 1'b0; m_r_data = '0; m_r_id = '0; m_r_last = 1'b0;
        s_r_ready = 1'b0;
        crs_outstLimit = 4'd0;
        stop_stim = 1'b0;
        repeat (2) tick();

        // Reset values
        check_eq("rst_s_ar_ready", {31'b0, s_ar_ready}, 0);
        check_eq("rst_m_r_ready", {31'b0, m_r_ready}, 0);
        check_eq("rst_m_ar_valid", {31'b0, m_ar_valid}, 0);
        check_eq("rst_s_r_valid", {31'b0, s_r_valid}, 0);
        check_eq("rst_outst_cnt", {28'b0, outstCnt}, 0);
        check_eq("rst_err", {31'b0, err_underflow}, 0);
        check_eq("rst_ar_payload", {m_ar_id, m_ar_len, m_ar_addr}, 0);
        check_eq("rst_r_payload", {15'b0, s_r_last, s_r_id, s_r_data}, 0);
        resetN = 1'b1;
        #1;
        check_eq("rel_s_ar_ready_low", {31'b0, s_ar_ready}, 0);
        tick();
        check_eq("rel_s_ar_ready_high", {31'b0, s_ar_ready}, 1);
        check_eq("rel_m_r_ready_high", {31'b0, m_r_ready}, 1);

        // Pass-through
        crs_outstLimit = 4'd3; m_ar_ready = 1'b1; s_r_ready = 1'b1;
        drive_ar(16'h0EEF, 8'd0, 8'd5);
        tick();
        s_ar_valid = 1'b0;
        check_eq("pt_m_ar_valid", {31'b0, m_ar_valid}, 1);
        check_eq("pt_m_ar_fields", {m_ar_id, m_ar_len, m_ar_addr}, 32'h0500_0EEF);
        tick();
        check_eq("pt_cnt_one", {28'b0, outstCnt}, 1);
        check_eq("pt_m_ar_done", {31'b0, m_ar_valid}, 0);
        drive_r(8'hA5, 8'd5, 1'b1);
        tick();
        m_r_valid = 1'b0;
        check_eq("pt_s_r_valid", {31'b0, s_r_valid}, 1);
        check_eq("pt_s_r_fields", {15'b0, s_r_last, s_r_id, s_r_data}, 32'h0001_05A5);
        check_eq("pt_cnt_zero", {28'b0, outstCnt}, 0);
        tick();
        check_eq("pt_s_r_done", {31'b0, s_r_valid}, 0);

        // AR backpressure
        m_ar_ready = 1'b0;
        drive_ar(16'h0100, 8'd1, 8'd1);
        tick();
        check_eq("bp_rdy_after1", {31'b0, s_ar_ready}, 1);
        drive_ar(16'h0200, 8'd1, 8'd2);
        tick();
        check_eq("bp_rdy_after2", {31'b0, s_ar_ready}, 0);
        drive_ar(16'h0300, 8'd1, 8'd3);
        tick();
        check_eq("bp_rdy_pending3", {31'b0, s_ar_ready}, 0);
        check_eq("bp_head_id1", {24'b0, m_ar_id}, 1);
        m_ar_ready = 1'b1;
        tick();
        check_eq("bp_head_id2", {24'b0, m_ar_id}, 2);
        check_eq("bp_valid_id2", {31'b0, m_ar_valid}, 1);
        check_eq("bp_rdy_back", {31'b0, s_ar_ready}, 1);
        tick();
        s_ar_valid = 1'b0;
        check_eq("bp_head_id3", {24'b0, m_ar_id}, 3);
        check_eq("bp_valid_id3", {31'b0, m_ar_valid}, 1);
        tick();
        check_eq("bp_empty", {31'b0, m_ar_valid}, 0);
        check_eq("bp_cnt_three", {28'b0, outstCnt}, 3);
        drive_r(8'h11, 8'h0, 1'b1);
        repeat (3) tick();
        m_r_valid = 1'b0;
        check_eq("bp_cnt_drained", {28'b0, outstCnt}, 0);

        // Limit gating
        crs_outstLimit = 4'd2;
        drive_ar(16'h1000, 8'd0, 8'd10); tick();
        drive_ar(16'h1100, 8'd0, 8'd11); tick();
        drive_ar(16'h1200, 8'd0, 8'd12); tick();
        s_ar_valid = 1'b0;
        check_eq("lim_gated", {31'b0, m_ar_valid}, 0);
        check_eq("lim_held_id", {24'b0, m_ar_id}, 12);
        check_eq("lim_cnt_two", {28'b0, outstCnt}, 2);
        tick();
        check_eq("lim_still_gated", {31'b0, m_ar_valid}, 0);
        last_beat_cycle();
        check_eq("lim_cnt_one", {28'b0, outstCnt}, 1);
        check_eq("lim_open", {31'b0, m_ar_valid}, 1);
        tick();
        check_eq("lim_cnt_back_two", {28'b0, outstCnt}, 2);
        check_eq("lim_third_issued", {31'b0, m_ar_valid}, 0);

        // Simultaneous AR issue and last beat
        last_beat_cycle();
        drive_ar(16'h2000, 8'd0, 8'd20);
        tick();
        s_ar_valid = 1'b0;
        check_eq("sim_ar_ready_to_go", {31'b0, m_ar_valid}, 1);
        check_eq("sim_cnt_before", {28'b0, outstCnt}, 1);
        last_beat_cycle();
        check_eq("sim_cnt_same", {28'b0, outstCnt}, 1);
        check_eq("sim_err_clear", {31'b0, err_underflow}, 0);
        last_beat_cycle();
        check_eq("sim_cnt_zero", {28'b0, outstCnt}, 0);

        // Underflow
        resetN = 1'b0; tick(); resetN = 1'b1; tick();
        crs_outstLimit = 4'd3;
        drive_r(8'h3C, 8'd7, 1'b1);
        tick();
        m_r_valid = 1'b0;
        check_eq("uf_s_r_valid", {31'b0, s_r_valid}, 1);
        check_eq("uf_s_r_id", {24'b0, s_r_id}, 7);
        check_eq("uf_err", {31'b0, err_underflow}, 1);
        check_eq("uf_cnt", {28'b0, outstCnt}, 0);
        repeat (2) tick();
        check_eq("uf_err_sticky", {31'b0, err_underflow}, 1);

        // Reset mid-operation
        m_ar_ready = 1'b0; s_r_ready = 1'b0;
        drive_ar(16'h3000, 8'd3, 8'd1); tick();
        drive_ar(16'h3100, 8'd3, 8'd2); tick();
        s_ar_valid = 1'b0;
        drive_r(8'h01, 8'd9, 1'b0); tick();
        drive_r(8'h02, 8'd9, 1'b0); tick();
        m_r_valid = 1'b0;
        check_eq("mid_ar_buffered", {31'b0, m_ar_valid}, 1);
        check_eq("mid_r_buffered", {31'b0, s_r_valid}, 1);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("mid_m_ar_valid", {31'b0, m_ar_valid}, 0);
        check_eq("mid_s_r_valid", {31'b0, s_r_valid}, 0);
        check_eq("mid_cnt", {28'b0, outstCnt}, 0);
        check_eq("mid_err", {31'b0, err_underflow}, 0);
        check_eq("mid_rdy", {30'b0, s_ar_ready, m_r_ready}, 0);
        tick();
        resetN = 1'b1;
        #1;
        check_eq("mid_rdy_rel", {30'b0, s_ar_ready, m_r_ready}, 0);
        tick();
        check_eq("mid_rdy_back", {30'b0, s_ar_ready, m_r_ready}, 3);

        // Randomized traffic against the model
        ar_exp_q.delete(); r_exp_q.delete(); ddr_q.delete();
        beat_idx = 0; cnt_m = 0; err_m = 1'b0;
        ar_in_hs = 1'b0; ar_out_hs = 1'b0; r_in_hs = 1'b0; r_out_hs = 1'b0;
        crs_outstLimit = 4'd3;
        repeat (3000) model_cycle();
        stop_stim = 1'b1;
        drain_cycles = 0;
        busy = 1'b1;
        while (busy && drain_cycles < 400) begin
            model_cycle();
            drain_cycles++;
            busy = (ar_exp_q.size() > 0) || (r_exp_q.size() > 0) || (ddr_q.size() > 0) ||
                   s_ar_valid || m_r_valid;
        end
        check_eq("drain_done", {31'b0, busy}, 0);
        check_eq("drain_cnt", {28'b0, outstCnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
